// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validates an access, drives one bus request until ack
// or timeout, and returns a single-cycle response with the extracted load data.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic [2:0]  sel_type,
    output logic [1:0]  sel_addr_old,
    input  logic [31:0] rd_mem,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TO_L = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  tcnt;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [1:0]  acc_err;

    // Illegal type outranks misalignment; 00 means the access goes to the bus.
    function automatic logic [1:0] access_err(input logic we, input logic [2:0] typ,
                                              input logic [1:0] off);
        logic [1:0] e;
        e = 2'b00;
        if (typ > 3'd4 || (we && typ > 3'd2))
            e = 2'b11;
        else if (((typ == 3'd1 || typ == 3'd4) && off[0]) || (typ == 3'd2 && off != 2'b00))
            e = 2'b01;
        return e;
    endfunction

    function automatic logic [3:0] byte_en(input logic we, input logic [2:0] typ,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            case (typ)
                3'd0:    be = 4'b0001 << off;
                3'd1:    be = off[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic we, input logic [2:0] typ,
                                              input logic [31:0] wd);
        logic [31:0] d;
        d = 32'd0;
        if (we) begin
            case (typ)
                3'd0:    d = {4{wd[7:0]}};
                3'd1:    d = {2{wd[15:0]}};
                default: d = wd;
            endcase
        end
        return d;
    endfunction

    assign acc_err   = access_err(req_we, req_type, req_addr[1:0]);
    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tcnt         <= 8'd0;
            we_q         <= 1'b0;
            rd_q         <= 5'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            sel_type     <= 3'd0;
            sel_addr_old <= 2'd0;
            resp_valid   <= 1'b0;
            resp_err     <= 2'd0;
            resp_data    <= 32'd0;
            resp_rd      <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        we_q         <= req_we;
                        rd_q         <= req_rd;
                        sel_type     <= req_type;
                        sel_addr_old <= req_addr[1:0];
                        if (acc_err != 2'b00) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= acc_err;
                            resp_data  <= 32'd0;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= BUS;
                            tcnt      <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= byte_en(req_we, req_type, req_addr[1:0]);
                            mem_wdata <= lane_data(req_we, req_type, req_wdata);
                        end
                    end
                end
                BUS: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (mem_ack || tcnt == TO_L) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_ack ? 2'b00 : 2'b10;
                        resp_data  <= (mem_ack && !we_q) ? rd_mem : 32'd0;
                        resp_rd    <= rd_q;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized and directed bench for lsu_ctrl, with a select_rd model on rd_mem
// and an access-level reference for bus signals, latency and responses.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_mem;
    logic [3:0]  mem_be;
    logic [2:0]  sel_type;
    logic [1:0]  sel_addr_old;
    logic        resp_valid, stall;
    logic [1:0]  resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .sel_type(sel_type), .sel_addr_old(sel_addr_old),
        .rd_mem(rd_mem), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_data(resp_data), .resp_rd(resp_rd), .stall(stall)
    );

    // Behaviour of the external select_rd extractor.
    function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] t,
                                            input logic [1:0] a);
        logic [31:0] sh;
        sh = d >> (8 * int'(a));
        case (t)
            3'd0: return {{24{sh[7]}}, sh[7:0]};
            3'd1: return a[1] ? {{16{d[31]}}, d[31:16]} : {{16{d[15]}}, d[15:0]};
            3'd2: return d;
            3'd3: return {24'd0, sh[7:0]};
            3'd4: return a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    assign rd_mem = extract(mem_rdata, sel_type, sel_addr_old);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access; dly = index of the mem_req cycle carrying ack (>TO means never).
    task automatic access(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] rd, input int dly,
                          input logic [31:0] rdata);
        logic [1:0]  e;
        logic [3:0]  be;
        logic [31:0] wd, data;
        int size;
        size = (t == 3'd1 || t == 3'd4) ? 2 : (t == 3'd2) ? 4 : 1;
        if (t > 3'd4 || (we && t > 3'd2)) e = 2'b11;
        else if ((a % size) != 0) e = 2'b01;
        else if (dly <= TO) e = 2'b00;
        else e = 2'b10;
        be = we ? 4'(((1 << size) - 1) << (a % 4)) : 4'b1111;
        wd = (size == 1) ? {4{w[7:0]}} : (size == 2) ? {2{w[15:0]}} : w;
        data = (e == 2'b00 && !we) ? extract(rdata, t, a[1:0]) : 32'd0;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a;
        req_wdata = w; req_rd = rd; mem_rdata = rdata;
        @(posedge clk);
        if (e == 2'b00 || e == 2'b10) begin
            for (int c = 0; c <= TO; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                check("mem_req", {31'd0, mem_req}, 32'd1);
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_be", {28'd0, mem_be}, {28'd0, be});
                check("mem_we", {31'd0, mem_we}, {31'd0, we});
                if (we) check("mem_wdata", mem_wdata, wd);
                check("sel", {27'd0, sel_type, sel_addr_old}, {27'd0, t, a[1:0]});
                check("stall_bus", {30'd0, stall, req_ready}, 32'd2);
                mem_ack = (c == dly);
                @(posedge clk);
                if (c == dly) break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b0;
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("mem_req_off", {31'd0, mem_req}, 32'd0);
        check("resp_err", {30'd0, resp_err}, {30'd0, e});
        check("resp_data", resp_data, data);
        check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        @(negedge clk);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("resp_hold", {30'd0, resp_err}, {30'd0, e});
        check("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready_stall", {30'd0, req_ready, stall}, 32'd2);
        check("rst_mem", {mem_req, mem_we, mem_be, 26'd0}, 32'd0);
        check("rst_resp", {resp_valid, resp_err, resp_rd, sel_type, sel_addr_old}, 32'd0);
        check("rst_data", resp_data | mem_addr | mem_wdata, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 3'd0, 32'h0000_1003, 32'd0, 5'd5, 0, 32'h80FF_0000);
        access(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd6, 3, 32'd0);
        access(1'b0, 3'd2, 32'h0000_0002, 32'd0, 5'd7, 0, 32'd0);
        access(1'b0, 3'd1, 32'h0000_0001, 32'd0, 5'd8, 0, 32'd0);
        access(1'b1, 3'd3, 32'h0000_0010, 32'd0, 5'd9, 0, 32'd0);
        access(1'b0, 3'd2, 32'h0000_0040, 32'd0, 5'd10, TO + 1, 32'hDEAD_BEEF);
        access(1'b0, 3'd2, 32'h0000_0044, 32'd0, 5'd11, TO, 32'hCAFE_F00D);

        // Back-to-back: store B waits while load HU occupies BUS and RESP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'd4; req_addr = 32'h3002;
        req_rd = 5'd12; mem_rdata = 32'h8001_0000;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_type = 3'd0; req_addr = 32'h3001; req_wdata = 32'h0000_005A;
        req_rd = 5'd13;
        check("b2b_ready_bus", {31'd0, req_ready}, 32'd0);
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        check("b2b_data1", resp_data, 32'h0000_8001);
        check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_idle", {30'd0, req_ready, mem_req}, 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_req2", {31'd0, mem_req}, 32'd1);
        check("b2b_be2", {28'd0, mem_be}, 32'd2);
        check("b2b_wd2", mem_wdata, 32'h5A5A_5A5A);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("b2b_resp2", {29'd0, resp_valid, resp_err}, 32'd4);
        check("b2b_rd2", {27'd0, resp_rd}, 32'd13);

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'd2; req_addr = 32'h50;
        req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_req", {31'd0, mem_req}, 32'd0);
        check("rst_async_out", {mem_we, mem_be, resp_valid, stall, 25'd0}, 32'd0);
        check("rst_async_data", mem_addr | mem_wdata | resp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stray_ack", {30'd0, resp_valid, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  t;
            logic [31:0] a;
            logic        we;
            t  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (we) t = 3'($urandom_range(0, 2));
                if (t == 3'd2) a[1:0] = 2'b00;
                else if (t == 3'd1 || t == 3'd4) a[0] = 1'b0;
            end
            access(we, t, a, $urandom, 5'($urandom), $urandom_range(0, TO + 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
